kamikaze_imem: RTL and testbench

- Instruction-memory responder: the far end of the core's fetch port. It accepts the fetch address and returns the 32-bit instruction word one cycle later.
- Supports halfword-aligned 32-bit fetches, which compressed instruction streams need. Uses two interleaved word banks (even/odd) so a word straddling a 32-bit boundary returns in a single cycle.
- Contains a byte-stream program loader with a valid/ready handshake. It holds the core in reset while filling memory.

---
 rtl/kamikaze_imem_pkg.sv | 25 ++
 rtl/kamikaze_imem_if.sv | 40 ++++
 rtl/kamikaze_imem_bank.sv | 35 +++
 rtl/kamikaze_imem.sv | 173 +++++++++++++++++
 tb/tb_kamikaze_imem.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/kamikaze_imem_pkg.sv
// Shared definitions for the kamikaze instruction memory.
//   NOP_INSTR  : word presented on the fetch port while the core is held
//   ld_state_e : program-loader FSM states
//   bank_aw()  : index width of one interleaved bank, given the word-index width
package kamikaze_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned DEFAULT_ADDR_W = 10;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone
  } ld_state_e;

  // Each bank holds half the words, so it needs one index bit less.
  function automatic int unsigned bank_aw(input int unsigned addr_w);
    return addr_w - 1;
  endfunction

  localparam int unsigned DEFAULT_BANK_AW = bank_aw(DEFAULT_ADDR_W);

endpackage

// File: rtl/kamikaze_imem_if.sv
// Fetch port and byte-stream loader port of the instruction memory.
//   slave  : memory side (kamikaze_imem)
//   master : core fetch unit / program loader side
interface kamikaze_imem_if;

  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        ld_start_i;
  logic [15:0] ld_len_i;
  logic [7:0]  ld_data_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic        core_hold_o;
  logic        ld_done_o;

  modport slave (
    input  im_addr_i,
    input  ld_start_i,
    input  ld_len_i,
    input  ld_data_i,
    input  ld_valid_i,
    output im_data_o,
    output ld_ready_o,
    output core_hold_o,
    output ld_done_o
  );

  modport master (
    output im_addr_i,
    output ld_start_i,
    output ld_len_i,
    output ld_data_i,
    output ld_valid_i,
    input  im_data_o,
    input  ld_ready_o,
    input  core_hold_o,
    input  ld_done_o
  );

endinterface

// File: rtl/kamikaze_imem_bank.sv
// One interleaved word bank: Depth x 32 synchronous RAM, one write port and one
// registered read port, write-first on an address collision.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write index
//   wdata_i : write data
//   raddr_i : read index, sampled on the clock edge
//   rdata_o : read data, valid the cycle after raddr_i
module kamikaze_imem_bank #(
  parameter int unsigned AddrW = 9,
  parameter int unsigned Depth = 512
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] r_mem [Depth];

  // No reset: memory contents must survive a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_o <= wdata_i;
    end else begin
      rdata_o <= r_mem[raddr_i];
    end
  end

endmodule

// File: rtl/kamikaze_imem.sv
// Instruction-memory responder with halfword-aligned 32-bit fetches and a
// byte-stream program loader that holds the core in reset while filling memory.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus_io : fetch port (im_addr_i -> im_data_o, latency 1) and loader port
//            (ld_start_i/ld_len_i, ld_data_i/ld_valid_i/ld_ready_o,
//            core_hold_o, ld_done_o)
module kamikaze_imem
  import kamikaze_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input logic            clk_i,
  input logic            rst_i,
  kamikaze_imem_if.slave bus_io
);

  localparam int unsigned BankW     = bank_aw(ADDR_W);
  localparam int unsigned BankDepth = DEPTH_WORDS / 2;

  ld_state_e   r_state;
  ld_state_e   w_state_next;
  logic [15:0] r_len;
  logic [15:0] r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [31:0] r_asm;
  logic        r_hold_mask;
  logic [1:0]  r_sel;

  logic             w_accept;
  logic             w_last_word;
  logic             w_hold;
  logic [ADDR_W-1:0] w_word;
  logic             w_half;
  logic [BankW-1:0] w_even_raddr;
  logic [BankW-1:0] w_odd_raddr;
  logic [31:0]      w_even_rdata;
  logic [31:0]      w_odd_rdata;
  logic             w_even_we;
  logic             w_odd_we;
  logic             w_unused_addr;

  assign w_accept    = bus_io.ld_valid_i && bus_io.ld_ready_o;
  assign w_last_word = (r_word_cnt + 16'd1) == r_len;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus_io.ld_start_i) w_state_next = (bus_io.ld_len_i == 16'd0) ? StDone : StRecv;
      StRecv:  if (w_accept && (r_byte_cnt == 2'd3)) w_state_next = StWrite;
      StWrite: w_state_next = w_last_word ? StDone : StRecv;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    bus_io.ld_ready_o = 1'b0;
    bus_io.ld_done_o  = 1'b0;
    w_hold            = 1'b0;
    unique case (r_state)
      StRecv: begin
        bus_io.ld_ready_o = 1'b1;
        w_hold            = 1'b1;
      end
      StWrite: w_hold = 1'b1;
      StDone:  bus_io.ld_done_o = 1'b1;
      default: ;
    endcase
  end

  assign bus_io.core_hold_o = w_hold;

  // Loader datapath; a reset discards any partially assembled word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len      <= 16'd0;
      r_word_cnt <= 16'd0;
      r_byte_cnt <= 2'd0;
      r_asm      <= 32'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus_io.ld_start_i) begin
            r_len      <= bus_io.ld_len_i;
            r_word_cnt <= 16'd0;
            r_byte_cnt <= 2'd0;
          end
        end
        StRecv: begin
          if (w_accept) begin
            r_asm[{r_byte_cnt, 3'b000} +: 8] <= bus_io.ld_data_i;
            r_byte_cnt                       <= r_byte_cnt + 2'd1;
          end
        end
        StWrite: r_word_cnt <= r_word_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Read addressing. A straddling fetch from an odd word needs the next even
  // word, which lives one row further down the even bank (wrapping at the top).
  assign w_word        = bus_io.im_addr_i[ADDR_W+1:2];
  assign w_half        = bus_io.im_addr_i[1];
  assign w_odd_raddr   = w_word[ADDR_W-1:1];
  assign w_even_raddr  = w_word[ADDR_W-1:1] + {{(BankW-1){1'b0}}, (w_half & w_word[0])};
  assign w_unused_addr = ^{bus_io.im_addr_i[31:ADDR_W+2], bus_io.im_addr_i[0]};

  assign w_even_we = (r_state == StWrite) && !r_word_cnt[0];
  assign w_odd_we  = (r_state == StWrite) &&  r_word_cnt[0];

  kamikaze_imem_bank #(
    .AddrW (BankW),
    .Depth (BankDepth)
  ) u_bank_even (
    .clk_i   (clk_i),
    .we_i    (w_even_we),
    .waddr_i (r_word_cnt[ADDR_W-1:1]),
    .wdata_i (r_asm),
    .raddr_i (w_even_raddr),
    .rdata_o (w_even_rdata)
  );

  kamikaze_imem_bank #(
    .AddrW (BankW),
    .Depth (BankDepth)
  ) u_bank_odd (
    .clk_i   (clk_i),
    .we_i    (w_odd_we),
    .waddr_i (r_word_cnt[ADDR_W-1:1]),
    .wdata_i (r_asm),
    .raddr_i (w_odd_raddr),
    .rdata_o (w_odd_rdata)
  );

  // r_sel aligns the lane select with the registered bank outputs; r_hold_mask
  // keeps NOP on the port for the cycle after hold drops, and after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sel       <= 2'd0;
      r_hold_mask <= 1'b1;
    end else begin
      r_sel       <= {w_half, w_word[0]};
      r_hold_mask <= w_hold;
    end
  end

  always_comb begin
    bus_io.im_data_o = NOP_INSTR;
    if (!(w_hold || r_hold_mask)) begin
      unique case (r_sel)
        2'b00:   bus_io.im_data_o = w_even_rdata;
        2'b01:   bus_io.im_data_o = w_odd_rdata;
        2'b10:   bus_io.im_data_o = {w_odd_rdata[15:0], w_even_rdata[31:16]};
        default: bus_io.im_data_o = {w_even_rdata[15:0], w_odd_rdata[31:16]};
      endcase
    end
  end

endmodule

// File: tb/tb_kamikaze_imem.sv
module tb_kamikaze_imem;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int n_vec  = 0;
  int n_miss = 0;

  kamikaze_imem_if bus ();

  kamikaze_imem #(
    .DEPTH_WORDS (1024),
    .ADDR_W      (10)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus_io (bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte stream generators: mode 0 = k, mode 1 = k[7:0]+k[15:8], mode 2 = k^A0
  function automatic logic [7:0] bgen(input int mode, input int k);
    logic [15:0] kk;
    kk = k[15:0];
    case (mode)
      1:       return kk[7:0] + kk[15:8];
      2:       return kk[7:0] ^ 8'hA0;
      default: return kk[7:0];
    endcase
  endfunction

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.im_addr_i = addr;
    tick();
    chk(tag, bus.im_data_o, exp);
  endtask

  // Runs a full load. pattern: check the 4-high/1-low ready cadence.
  // throttle: valid only on even cycles. poke: pulse ld_start_i mid-load.
  task automatic do_load(input logic [15:0] len, input int mode, input bit pattern,
                         input bit throttle, input bit poke);
    int k;
    int c;
    int budget;
    bit acc;
    k      = 0;
    c      = 0;
    budget = int'(len) * 20 + 20;
    bus.ld_valid_i = 1'b0;
    bus.ld_len_i   = len;
    bus.ld_start_i = 1'b1;
    tick();
    bus.ld_start_i = 1'b0;
    while (bus.ld_done_o !== 1'b1 && c < budget) begin
      if (c < 12 || c % 97 == 0) begin
        chk("load_hold", {31'd0, bus.core_hold_o}, 32'd1);
        chk("load_nop", bus.im_data_o, NOP);
      end
      if (pattern) chk("load_ready", {31'd0, bus.ld_ready_o}, {31'd0, (c % 5) != 4});
      if (poke) begin
        bus.ld_start_i = (c == 2);
        bus.ld_len_i   = (c == 2) ? 16'd1 : len;
      end
      bus.ld_valid_i = throttle ? ((c % 2) == 0) : 1'b1;
      bus.ld_data_i  = bgen(mode, k);
      acc = bus.ld_valid_i && bus.ld_ready_o;
      tick();
      if (acc) k++;
      c++;
    end
    bus.ld_start_i = 1'b0;
    chk("load_timeout", {31'd0, c >= budget}, 32'd0);
    chk("load_done", {31'd0, bus.ld_done_o}, 32'd1);
    chk("load_hold_drop", {31'd0, bus.core_hold_o}, 32'd0);
    chk("load_bytes", k, int'(len) * 4);
    bus.ld_valid_i = 1'b0;
    tick();
    chk("load_done_pulse", {31'd0, bus.ld_done_o}, 32'd0);
  endtask

  initial begin
    int k;
    int c;
    bit acc;
    bus.im_addr_i  = 32'd0;
    bus.ld_start_i = 1'b0;
    bus.ld_len_i   = 16'd0;
    bus.ld_data_i  = 8'd0;
    bus.ld_valid_i = 1'b0;

    // Reset state
    #12;
    chk("rst_data", bus.im_data_o, NOP);
    chk("rst_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    chk("rst_hold", {31'd0, bus.core_hold_o}, 32'd0);
    chk("rst_done", {31'd0, bus.ld_done_o}, 32'd0);
    rst_i = 1'b0;
    tick();
    tick();
    chk("idle_ready", {31'd0, bus.ld_ready_o}, 32'd0);

    // Unthrottled load of bytes 00..0F
    do_load(16'd4, 0, 1'b1, 1'b0, 1'b0);
    fetch("rd_0", 32'h0, 32'h0302_0100);
    fetch("rd_4", 32'h4, 32'h0706_0504);
    fetch("rd_2", 32'h2, 32'h0504_0302);
    fetch("rd_6", 32'h6, 32'h0908_0706);
    fetch("rd_c", 32'hC, 32'h0F0E_0D0C);
    fetch("rd_a", 32'hA, 32'h0D0C_0B0A);

    // Overlong load: 1026 words, words 1024/1025 wrap onto 0/1
    do_load(16'd1026, 1, 1'b0, 1'b0, 1'b0);
    fetch("wrap_w0", 32'h0, 32'h1312_1110);
    fetch("wrap_w1", 32'h4, 32'h1716_1514);
    fetch("wrap_w2", 32'h8, 32'h0B0A_0908);
    fetch("wrap_last", 32'hFFC, 32'h0E0D_0C0B);
    fetch("wrap_straddle", 32'hFFE, 32'h1110_0E0D);
    fetch("wrap_upper", 32'h1000, 32'h1312_1110);
    fetch("bit0_ignored", 32'h3, 32'h1514_1312);

    // Throttled load with a stray start pulse, restores 00..0F
    do_load(16'd4, 0, 1'b0, 1'b1, 1'b1);
    fetch("thr_0", 32'h0, 32'h0302_0100);
    fetch("thr_4", 32'h4, 32'h0706_0504);
    fetch("thr_8", 32'h8, 32'h0B0A_0908);
    fetch("thr_c", 32'hC, 32'h0F0E_0D0C);

    // Zero-length load
    bus.ld_len_i   = 16'd0;
    bus.ld_start_i = 1'b1;
    tick();
    bus.ld_start_i = 1'b0;
    chk("len0_done", {31'd0, bus.ld_done_o}, 32'd1);
    chk("len0_hold", {31'd0, bus.core_hold_o}, 32'd0);
    tick();
    chk("len0_done_pulse", {31'd0, bus.ld_done_o}, 32'd0);
    chk("len0_hold2", {31'd0, bus.core_hold_o}, 32'd0);
    fetch("len0_mem", 32'h0, 32'h0302_0100);

    // Reset after 6 accepted bytes of a len=4 load
    bus.ld_len_i   = 16'd4;
    bus.ld_start_i = 1'b1;
    tick();
    bus.ld_start_i = 1'b0;
    k = 0;
    c = 0;
    while (k < 6 && c < 50) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_data_i  = bgen(2, k);
      acc = bus.ld_ready_o;
      tick();
      if (acc) k++;
      c++;
    end
    chk("midrst_bytes", k, 6);
    chk("midrst_hold_before", {31'd0, bus.core_hold_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst_data", bus.im_data_o, NOP);
    chk("midrst_hold", {31'd0, bus.core_hold_o}, 32'd0);
    chk("midrst_ready", {31'd0, bus.ld_ready_o}, 32'd0);
    bus.ld_valid_i = 1'b0;
    #3;
    rst_i = 1'b0;
    tick();
    tick();
    chk("postrst_idle", {31'd0, bus.ld_ready_o}, 32'd0);
    fetch("postrst_w0", 32'h0, 32'hA3A2_A1A0);
    fetch("postrst_w1", 32'h4, 32'h0706_0504);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
